// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR filter. One multiply-accumulate unit
// is stepped over order+1 taps for each accepted input sample.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   Data_in, in_valid     input sample and its valid; accepted only in IDLE
//   in_ready              high while the block can accept a sample (IDLE)
//   Data_out, out_valid   filtered result (held) and one-cycle update pulse
//   cfg_we/addr/data      coefficient write port (IDLE only, addr 0..order)
//   cfg_err               one-cycle pulse for a rejected coefficient write
//   busy                  high while the MAC sequence is running
module fir_mac_sequencer #(
  parameter int unsigned order         = 8,
  parameter int unsigned word_size_in  = 8,
  parameter int unsigned coeff_width   = 8,
  parameter int unsigned word_size_out = word_size_in + coeff_width + 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [word_size_in-1:0]  Data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [word_size_out-1:0] Data_out,
  output logic                     out_valid,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [coeff_width-1:0]   cfg_data,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int unsigned TAP_W  = $clog2(order + 1);
  localparam int unsigned PROD_W = coeff_width + word_size_in;

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  state_t                   state, state_next;
  logic [TAP_W-1:0]         tap;
  logic [word_size_out-1:0] acc;
  logic [word_size_in-1:0]  x_cur;
  logic [word_size_in-1:0]  samples [0:order-1];
  logic [coeff_width-1:0]   coeff   [0:order];

  logic                     accept_c, last_c, cfg_ok_c, cfg_bad_c;
  logic [word_size_in-1:0]  op_c;
  logic [coeff_width-1:0]   cf_c;
  logic [PROD_W-1:0]        prod_c;
  logic [word_size_out-1:0] mac_sum_c;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control strobes
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        if (tap == TAP_W'(order)) begin
          last_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Coefficient writes are only legal in IDLE and within 0..order
  always_comb begin
    cfg_ok_c  = cfg_we && (state == IDLE) && (32'(cfg_addr) <= order);
    cfg_bad_c = cfg_we && !cfg_ok_c;
  end

  // Tap operand/coefficient select: tap 0 uses the current sample x(n)
  always_comb begin
    op_c = x_cur;
    cf_c = coeff[0];
    for (int unsigned k = 1; k <= order; k++) begin
      if (tap == TAP_W'(k)) begin
        op_c = samples[k-1];
        cf_c = coeff[k];
      end
    end
    prod_c    = PROD_W'(cf_c) * PROD_W'(op_c);
    mac_sum_c = acc + word_size_out'(prod_c);
  end

  // Datapath, delay line, coefficient file and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      tap       <= '0;
      acc       <= '0;
      x_cur     <= '0;
      Data_out  <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      for (int unsigned k = 0; k < order; k++) samples[k] <= '0;
      for (int unsigned k = 0; k <= order; k++) coeff[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      cfg_err   <= cfg_bad_c;
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next == MAC);

      for (int unsigned k = 0; k <= order; k++) begin
        if (cfg_ok_c && (cfg_addr == 4'(k))) coeff[k] <= cfg_data;
      end

      if (accept_c) begin
        x_cur      <= Data_in;
        samples[0] <= x_cur;
        for (int unsigned k = 1; k < order; k++) samples[k] <= samples[k-1];
        acc        <= '0;
        tap        <= '0;
      end else if (state == MAC) begin
        acc <= mac_sum_c;
        if (last_c) begin
          tap       <= '0;
          Data_out  <= mac_sum_c;
          out_valid <= 1'b1;
        end else begin
          tap <= tap + TAP_W'(1);
        end
      end
    end
  end

endmodule
